mbist_march_sequencer: RTL and testbench

Self-contained March C- sequencer for one single-port SRAM under BIST. On `start` it walks every address through six March elements, issuing one read or write per cycle, and compares read data against the expected background. It reports done, a sticky fail flag, and first-failure diagnostics. It sits between the BIST controller's start/NbarT control and the memory's test-mode port.

---
 rtl/mbist_pkg.sv | 91 +++++++++
 rtl/mbist_addr_gen.sv | 52 +++++
 rtl/mbist_march_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_mbist_march_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// -----------------------------------------------------------------------------
// mbist_pkg
// Shared types and the fixed March C- element table used by the MBIST march
// sequencer and its address generator.
//   state_t     : sequencer FSM states (IDLE, RUN, DRAIN, DONE)
//   op_t        : memory operation of one March step (w0, w1, r0, r1)
//   MARCH_TABLE : per element {direction, op count, first op, second op}
// -----------------------------------------------------------------------------
package mbist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_W0 = 2'd0,
    OP_W1 = 2'd1,
    OP_R0 = 2'd2,
    OP_R1 = 2'd3
  } op_t;

  localparam int         NUM_ELEM  = 6;
  localparam logic [2:0] LAST_ELEM = 3'd5;

  // dir: 0 = ascending addresses, 1 = descending addresses
  typedef struct packed {
    logic       dir;
    logic [1:0] nops;
    op_t        op0;
    op_t        op1;
  } elem_t;

  // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) down(r0)
  // Single-op elements repeat their op in the unused slot.
  localparam elem_t MARCH_TABLE [NUM_ELEM] = '{
    '{1'b0, 2'd1, OP_W0, OP_W0},
    '{1'b0, 2'd2, OP_R0, OP_W1},
    '{1'b0, 2'd2, OP_R1, OP_W0},
    '{1'b1, 2'd2, OP_R0, OP_W1},
    '{1'b1, 2'd2, OP_R1, OP_W0},
    '{1'b1, 2'd1, OP_R0, OP_R0}
  };

  // Number of ops in element idx (0 for indices outside the table).
  function automatic logic [1:0] elem_nops(input logic [2:0] idx);
    logic [1:0] n;
    if (idx <= LAST_ELEM) begin
      n = MARCH_TABLE[idx].nops;
    end else begin
      n = 2'd0;
    end
    return n;
  endfunction

  // Address direction of element idx.
  function automatic logic elem_dir(input logic [2:0] idx);
    logic d;
    if (idx <= LAST_ELEM) begin
      d = MARCH_TABLE[idx].dir;
    end else begin
      d = 1'b0;
    end
    return d;
  endfunction

  // Op number sel (0 or 1) of element idx.
  function automatic op_t elem_op(input logic [2:0] idx, input logic sel);
    op_t o;
    if (idx > LAST_ELEM) begin
      o = OP_W0;
    end else if (sel) begin
      o = MARCH_TABLE[idx].op1;
    end else begin
      o = MARCH_TABLE[idx].op0;
    end
    return o;
  endfunction

  function automatic logic op_is_write(input op_t op);
    return (op == OP_W0) || (op == OP_W1);
  endfunction

  // Background bit written, or expected on a read, by this op.
  function automatic logic op_bg(input op_t op);
    return (op == OP_W1) || (op == OP_R1);
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// -----------------------------------------------------------------------------
// mbist_addr_gen
// Loadable up/down address counter for the March sequencer. A load presets the
// counter to the first address of the chosen direction; a step moves one word
// and wraps naturally inside the ADDR_W-bit range.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : preset to 0 (dir=0) or N-1 (dir=1) and latch the direction
//   dir      : direction applied on load
//   step     : advance one address in the latched direction
//   addr     : current address (registered)
//   last     : addr is the final address of the current direction
// -----------------------------------------------------------------------------
module mbist_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              dir,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic dir_r;

  // address register and latched direction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= {ADDR_W{1'b0}};
      dir_r <= 1'b0;
    end else if (load) begin
      dir_r <= dir;
      addr  <= dir ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
    end else if (step) begin
      addr <= dir_r ? (addr - ADDR_W'(1'b1)) : (addr + ADDR_W'(1'b1));
    end else begin
      addr <= addr;
    end
  end

  // end-of-sweep flag for the current direction
  always_comb begin
    if (dir_r) begin
      last = (addr == {ADDR_W{1'b0}});
    end else begin
      last = (addr == {ADDR_W{1'b1}});
    end
  end

endmodule

// File: rtl/mbist_march_sequencer.sv
// -----------------------------------------------------------------------------
// mbist_march_sequencer
// March C- sequencer for one single-port SRAM. On start it runs the six March
// elements over all 2**ADDR_W words, one read or write per cycle, compares each
// read against the expected background one cycle later and reports done, a
// sticky fail flag and the address/element of the first mismatch.
//
// Optional feature: define MBIST_STOP_ON_FAIL_EN to abort the run at the first
// mismatch (DONE entered at the edge that sets fail, further ops squashed).
// Without it the run always completes and fail only accumulates.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a test (honoured in IDLE and DONE only)
//   mem_addr   : memory address (registered)
//   mem_wdata  : background word; write data, also the expected data of reads
//   mem_we     : write strobe
//   mem_re     : read strobe
//   mem_rdata  : read data, valid the cycle after mem_re
//   busy       : test in progress (RUN or DRAIN)
//   done       : test finished, held until the next start
//   fail       : sticky mismatch flag
//   fail_addr  : address of the first mismatch
//   fail_elem  : March element (0-5) of the first mismatch
// -----------------------------------------------------------------------------
module mbist_march_sequencer
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem
);

  // Position of the op currently on the memory port
  state_t      state_r;
  logic [2:0]  elem_r;
  logic        opidx_r;

  // Compare stage: the read issued last cycle
  logic              cmp_valid_r;
  logic [DATA_W-1:0] cmp_exp_r;
  logic [ADDR_W-1:0] cmp_addr_r;
  logic [2:0]        cmp_elem_r;

  logic        addr_last_s;
  logic        gen_load_s;
  logic        gen_dir_s;
  logic        gen_step_s;
  logic        last_op_s;
  logic        run_end_s;
  logic [2:0]  nxt_elem_s;
  logic        nxt_opidx_s;
  op_t         nxt_op_s;
  logic        mismatch_s;
  logic        first_mis_s;
  logic        abort_s;

  mbist_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .load (gen_load_s),
    .dir  (gen_dir_s),
    .step (gen_step_s),
    .addr (mem_addr),
    .last (addr_last_s)
  );

  // next op position and address-generator control
  always_comb begin
    nxt_elem_s  = elem_r;
    nxt_opidx_s = opidx_r;
    gen_load_s  = 1'b0;
    gen_dir_s   = 1'b0;
    gen_step_s  = 1'b0;
    run_end_s   = 1'b0;
    last_op_s   = (({1'b0, opidx_r} + 2'd1) == elem_nops(elem_r));
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          nxt_elem_s  = 3'd0;
          nxt_opidx_s = 1'b0;
          gen_load_s  = 1'b1;
          gen_dir_s   = elem_dir(3'd0);
        end else begin
          nxt_elem_s  = elem_r;
        end
      end
      RUN: begin
        if (!last_op_s) begin
          nxt_opidx_s = 1'b1;
        end else if (!addr_last_s) begin
          nxt_opidx_s = 1'b0;
          gen_step_s  = 1'b1;
        end else if (elem_r == LAST_ELEM) begin
          run_end_s   = 1'b1;
        end else begin
          nxt_elem_s  = elem_r + 3'd1;
          nxt_opidx_s = 1'b0;
          gen_load_s  = 1'b1;
          gen_dir_s   = elem_dir(elem_r + 3'd1);
        end
      end
      default: begin
        nxt_elem_s = elem_r;
      end
    endcase
    nxt_op_s = elem_op(nxt_elem_s, nxt_opidx_s);
  end

  // read-data check and optional abort
  always_comb begin
    mismatch_s  = cmp_valid_r && (mem_rdata != cmp_exp_r);
    first_mis_s = mismatch_s && !fail;
`ifdef MBIST_STOP_ON_FAIL_EN
    abort_s     = first_mis_s && (state_r == RUN);
`else
    abort_s     = 1'b0;
`endif
  end

  // FSM, registered op outputs, compare stage and first-failure capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      elem_r      <= 3'd0;
      opidx_r     <= 1'b0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_wdata   <= {DATA_W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fail_addr   <= {ADDR_W{1'b0}};
      fail_elem   <= 3'd0;
      cmp_valid_r <= 1'b0;
      cmp_exp_r   <= {DATA_W{1'b0}};
      cmp_addr_r  <= {ADDR_W{1'b0}};
      cmp_elem_r  <= 3'd0;
    end else begin
      // a read squashed by an abort must not be compared afterwards
      cmp_valid_r <= mem_re & ~abort_s;
      cmp_exp_r   <= mem_wdata;
      cmp_addr_r  <= mem_addr;
      cmp_elem_r  <= elem_r;

      if (first_mis_s) begin
        fail      <= 1'b1;
        fail_addr <= cmp_addr_r;
        fail_elem <= cmp_elem_r;
      end else begin
        fail      <= fail;
      end

      case (state_r)
        IDLE, DONE: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          if (start) begin
            state_r   <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= {ADDR_W{1'b0}};
            fail_elem <= 3'd0;
            elem_r    <= nxt_elem_s;
            opidx_r   <= nxt_opidx_s;
            mem_we    <= op_is_write(nxt_op_s);
            mem_re    <= ~op_is_write(nxt_op_s);
            mem_wdata <= {DATA_W{op_bg(nxt_op_s)}};
          end else begin
            state_r   <= state_r;
          end
        end
        RUN: begin
          if (abort_s) begin
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            mem_we  <= 1'b0;
            mem_re  <= 1'b0;
          end else if (run_end_s) begin
            state_r <= DRAIN;
            mem_we  <= 1'b0;
            mem_re  <= 1'b0;
          end else begin
            elem_r    <= nxt_elem_s;
            opidx_r   <= nxt_opidx_s;
            mem_we    <= op_is_write(nxt_op_s);
            mem_re    <= ~op_is_write(nxt_op_s);
            mem_wdata <= {DATA_W{op_bg(nxt_op_s)}};
          end
        end
        DRAIN: begin
          // final M5 read is compared during this cycle
          state_r <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          mem_we  <= 1'b0;
          mem_re  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          mem_we  <= 1'b0;
          mem_re  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_march_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mbist_march_sequencer
// Directed bench for the March C- sequencer with a 16x8 RAM model that can
// hold one stuck-at fault. Each run pushes its hand-computed summary into a
// scoreboard queue; a monitor accumulates op/busy statistics on the falling
// edge and pops/compares when done rises.
//
// Hand-derived figures for N=16 (element table w0 | r0,w1 | r1,w0 | r0,w1 |
// r1,w0 | r0): 160 ops = 80 writes + 80 reads, busy for 160 op cycles plus the
// DRAIN cycle = 161. Stop-on-fail with bit3 SA1 at addr 5: M1 read of addr 5
// in cycle 16+2*5=26, compared in cycle 27, so busy spans cycles 0..27 and the
// ops seen are 16+5+1 writes, 5+1 reads, the last being the w1 of addr 5.
// -----------------------------------------------------------------------------
module tb_mbist_march_sequencer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;

  mbist_march_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .fail_addr (fail_addr),
    .fail_elem (fail_elem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model with one optional stuck-at fault applied to the stored word
  logic [DATA_W-1:0] mem [16];
  int                sa_addr;
  logic [DATA_W-1:0] sa1_mask;
  logic [DATA_W-1:0] sa0_mask;

  always @(posedge clk) begin
    if (mem_we) begin
      if (int'(mem_addr) == sa_addr) begin
        mem[mem_addr] <= (mem_wdata | sa1_mask) & ~sa0_mask;
      end else begin
        mem[mem_addr] <= mem_wdata;
      end
    end
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    string name;
    int    busy_cyc;
    int    wr;
    int    rd;
    int    fl;
    int    fa;
    int    fe;
    int    lo_we;
    int    lo_addr;
  } exp_t;

  exp_t expq[$];

  int total;
  int bad;

  // monitor statistics
  logic clr_cnt;
  logic done_q;
  int   busy_cnt, wr_cnt, rd_cnt, overlap_cnt, post_ops;
  int   seen_op;
  int   fo_we, fo_addr, fo_wdata, lo_we, lo_addr;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (clr_cnt) begin
        busy_cnt = 0; wr_cnt = 0; rd_cnt = 0; overlap_cnt = 0; post_ops = 0;
        seen_op = 0; fo_we = 0; fo_addr = 0; fo_wdata = 0; lo_we = 0; lo_addr = 0;
      end else begin
        if (busy) busy_cnt++;
        if (mem_we) wr_cnt++;
        if (mem_re) rd_cnt++;
        if (mem_we && mem_re) overlap_cnt++;
        if ((mem_we || mem_re) && done) post_ops++;
        if (mem_we || mem_re) begin
          if (seen_op == 0) begin
            fo_we = int'(mem_we); fo_addr = int'(mem_addr); fo_wdata = int'(mem_wdata);
            seen_op = 1;
          end
          lo_we = int'(mem_we); lo_addr = int'(mem_addr);
        end
        if (done && !done_q) begin
          if (expq.size() == 0) begin
            check("sb_unexpected_done", 1, 0);
          end else begin
            e = expq.pop_front();
            check({e.name, "_busy_cycles"}, busy_cnt, e.busy_cyc);
            check({e.name, "_writes"}, wr_cnt, e.wr);
            check({e.name, "_reads"}, rd_cnt, e.rd);
            check({e.name, "_fail"}, int'(fail), e.fl);
            check({e.name, "_fail_addr"}, int'(fail_addr), e.fa);
            check({e.name, "_fail_elem"}, int'(fail_elem), e.fe);
            check({e.name, "_first_we"}, fo_we, 1);
            check({e.name, "_first_addr"}, fo_addr, 0);
            check({e.name, "_first_wdata"}, fo_wdata, 0);
            check({e.name, "_last_we"}, lo_we, e.lo_we);
            check({e.name, "_last_addr"}, lo_addr, e.lo_addr);
            check({e.name, "_we_re_overlap"}, overlap_cnt, 0);
          end
        end
      end
      done_q = done;
    end
  endtask

  task automatic run_case(input exp_t e, input int mid_start);
    @(posedge clk); #1 clr_cnt = 1'b1;
    @(posedge clk); #1 clr_cnt = 1'b0;
    expq.push_back(e);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({e.name, "_busy_after_start"}, int'(busy), 1);
    check({e.name, "_fail_cleared"}, int'(fail), 0);
    check({e.name, "_done_cleared"}, int'(done), 0);
    if (mid_start > 0) begin
      repeat (mid_start) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk); #1;
    end
    check({e.name, "_done_timeout"}, int'(done), 1);
    repeat (4) @(posedge clk);
    #1;
    check({e.name, "_done_held"}, int'(done), 1);
    check({e.name, "_busy_low"}, int'(busy), 0);
    check({e.name, "_ops_after_done"}, post_ops, 0);
  endtask

  initial begin
    exp_t clean;
    exp_t t3;
    exp_t t5;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    clr_cnt  = 1'b0;
    done_q   = 1'b0;
    sa_addr  = -1;
    sa1_mask = 8'h00;
    sa0_mask = 8'h00;
    fork
      monitor_loop();
    join_none

    // power-on reset state
    #3;
    check("por_busy", int'(busy), 0);
    check("por_done", int'(done), 0);
    check("por_fail", int'(fail), 0);

    // test 1: asynchronous reset in the middle of a run (t=50 is mid-cycle)
    #9  rst   = 1'b0;              // t=12
    #5  start = 1'b1;              // t=17, sampled at the edge at t=25
    #10 start = 1'b0;              // t=27
    #22;                           // t=49, M0 writes in progress
    check("pre_rst_busy", int'(busy), 1);
    check("pre_rst_we", int'(mem_we), 1);
    #1  rst = 1'b1;                // t=50
    #1;                            // t=51, no clock edge since reset
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fail", int'(fail), 0);
    check("rst_we", int'(mem_we), 0);
    check("rst_re", int'(mem_re), 0);
    #6  rst = 1'b0;                // t=57

    clean = '{"t2_clean", 161, 80, 80, 0, 0, 0, 0, 0};
`ifdef MBIST_STOP_ON_FAIL_EN
    t3 = '{"t4_stop_sa1_a5", 28, 22, 6, 1, 5, 1, 1, 5};
    // M2 read of addr 15 in cycle 48+30=78, compared in cycle 79
    t5 = '{"t5_stop_sa0_a15", 80, 48, 32, 1, 15, 2, 1, 15};
`else
    t3 = '{"t3_sa1_a5", 161, 80, 80, 1, 5, 1, 0, 0};
    t5 = '{"t5_sa0_a15", 161, 80, 80, 1, 15, 2, 0, 0};
`endif

    // test 2: fault-free run after the abandoned one
    run_case(clean, 0);

    // test 3/4: bit 3 stuck-at-1 at address 5
    sa_addr = 5; sa1_mask = 8'h08; sa0_mask = 8'h00;
    run_case(t3, 0);

    // test 5: bit 0 stuck-at-0 at address 15 (M2 first, M4 later)
    sa_addr = 15; sa1_mask = 8'h00; sa0_mask = 8'h01;
    run_case(t5, 0);

    // test 6: restart from DONE after a failing run, fault removed
    sa_addr = -1; sa1_mask = 8'h00; sa0_mask = 8'h00;
    clean.name = "t6_rerun_clean";
    run_case(clean, 0);

    // test 6: start pulse during RUN is ignored
    clean.name = "t6_start_in_run";
    run_case(clean, 40);

    check("sb_leftover", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
